// File: rtl/pe_pkg.sv
// pe_pkg: shared widths and window bit mapping for the convolution PE and its feeders
package pe_pkg;
    localparam int BIT_W = 8;
    localparam int CH_N = 2;
    localparam int K = 3;
    localparam int PIX_W = CH_N * BIT_W;
    localparam int PE_IMAGE_W = CH_N * K * K * BIT_W;
    function automatic int win_msb(int c, int r, int k);
        return PE_IMAGE_W - 1 - BIT_W * (K * K * c + K * r + k);
    endfunction
endpackage

// File: rtl/pe_line_mem.sv
// pe_line_mem: one image row of pixels, synchronous write / asynchronous read at a shared address
module pe_line_mem import pe_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIX_W-1:0]         wdata,
    output logic [PIX_W-1:0]         rdata
);
    logic [PIX_W-1:0] mem [DEPTH];
    assign rdata = mem[addr];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
endmodule

// File: rtl/pe_window_gen.sv
// pe_window_gen: turns a raster pixel stream into valid-only 3x3x2 windows for the PE
module pe_window_gen import pe_pkg::*; #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sof,
    input  logic [PIX_W-1:0]      i_pixel,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [PE_IMAGE_W-1:0] o_window
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic acc, col_end;
    logic [PIX_W-1:0] lb0_q, lb1_q;
    logic [BIT_W-1:0] win [CH_N][K][K];
    assign o_ready = i_ready | ~o_valid;
    assign acc = i_valid & o_ready;
    // an accepted sof pixel restarts the frame regardless of where the counters are
    assign cur_col = i_sof ? '0 : col;
    assign cur_row = i_sof ? '0 : row;
    assign col_end = cur_col == CW'(IMG_W - 1);
    pe_line_mem #(.DEPTH(IMG_W)) lb0 (.clk(i_clk), .we(acc), .addr(cur_col), .wdata(i_pixel), .rdata(lb0_q));
    pe_line_mem #(.DEPTH(IMG_W)) lb1 (.clk(i_clk), .we(acc), .addr(cur_col), .wdata(lb0_q), .rdata(lb1_q));
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            col <= '0;
            row <= '0;
            o_valid <= 1'b0;
        end else if (acc) begin
            col <= col_end ? '0 : cur_col + 1'b1;
            row <= col_end ? (cur_row == RW'(IMG_H - 1) ? '0 : cur_row + 1'b1) : cur_row;
            o_valid <= cur_row >= RW'(2) && cur_col >= CW'(2);
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            for (int i = 0; i < CH_N; i++)
                for (int j = 0; j < K; j++)
                    for (int m = 0; m < K; m++)
                        win[i][j][m] <= '0;
        end else if (acc) begin
            for (int i = 0; i < CH_N; i++) begin
                for (int j = 0; j < K; j++) begin
                    win[i][j][0] <= win[i][j][1];
                    win[i][j][1] <= win[i][j][2];
                end
                win[i][0][2] <= lb1_q[PIX_W-1-BIT_W*i -: BIT_W];
                win[i][1][2] <= lb0_q[PIX_W-1-BIT_W*i -: BIT_W];
                win[i][2][2] <= i_pixel[PIX_W-1-BIT_W*i -: BIT_W];
            end
        end
    for (genvar c = 0; c < CH_N; c++) begin : g_ch
        for (genvar r = 0; r < K; r++) begin : g_row
            for (genvar k = 0; k < K; k++) begin : g_col
                assign o_window[win_msb(c, r, k) -: BIT_W] = win[c][r][k];
            end
        end
    end
endmodule
